hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle unsigned multiply/divide sequencer for the EX stage of the pipelined CPU. Runs alongside the single-cycle ALU.
- Owns the HI/LO registers and runs one shift-add multiply (MULTU) or restoring divide (DIVU), one bit per cycle.
- Raises a stall to the hazard logic when the pipeline touches HI/LO or issues a new op while a previous op is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  issue request from EX stage
is_div  input  1  operation select, sampled with start: 0 = MULTU, 1 = DIVU
a  input  WIDTH  multiplicand / dividend, sampled with start
b  input  WIDTH  multiplier / divisor, sampled with start
rd_hilo  input  1  EX holds MFHI/MFLO
wr_hi  input  1  MTHI write enable
wr_lo  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register (remainder / product upper half)
lo  output  WIDTH  LO register (quotient / product lower half)
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
stall  output  1  freeze PC, IF/ID and ID/EX this cycle

Behaviour:
- Reset (async, immediate on rst rising):
  - state=IDLE, cnt=0, all internal accumulators 0.
  - hi=0, lo=0, busy=0, done=0, stall=0.
  - Reset mid-operation abandons the op; HI/LO do not keep partial or old values.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 → RUN. Latch a, b, is_div; cnt<=0. Call this edge E0.
  - IDLE with start=0 stays IDLE. DONE with start=0 goes to IDLE.
  - RUN: one iteration per edge. At edge E32 (cnt==WIDTH-1) the final result is written to hi/lo and state goes to DONE.
- Outputs vs state:
  - busy=1 exactly while state==RUN, i.e. the WIDTH cycles between E0 and E32.
  - done=1 for the single cycle between E32 and E33.
  - Back-to-back issue: start in DONE is accepted. busy rises at E33 and done drops.
- Latency: result visible on hi/lo WIDTH+1 cycles after the cycle in which start was high.
- MULTU datapath:
  - 2*WIDTH accumulator {P_hi, P_lo}; P_lo loaded with b, P_hi with 0.
  - Each step: if P_lo[0], form WIDTH+1-bit sum P_hi+a, otherwise {0,P_hi}. Shift {sum,P_lo} right by 1.
  - Final: hi=P_hi, lo=P_lo. Full 64-bit product, no overflow.
- DIVU datapath (restoring):
  - R (WIDTH+1 bits)=0, Q=a.
  - Each step: shift {R,Q} left by 1. If R>=b then R-=b and Q[0]=1.
  - Final: lo=Q, hi=R[WIDTH-1:0].
  - Divide-by-zero is not special-cased and falls out of the algorithm: lo=all ones, hi=a, same latency.
- MTHI/MTLO:
  - wr_hi/wr_lo take effect at the edge only when state!=RUN.
  - During RUN they are ignored and stall is raised.
  - If wr_* and start are high in the same IDLE/DONE cycle, both are performed. The wr_* value is visible until E32, where the op result overwrites it.
- Stall rule: stall = busy & (start | rd_hilo | wr_hi | wr_lo). It is combinational, with no added latency.
- Ignored inputs:
  - start during RUN is ignored; stall holds the instruction until it re-presents.
  - Inputs a, b, is_div are don't-care outside the start edge.
- hi/lo change only at E32, at a wr_* edge, or on reset. They hold through IDLE and DONE.

Test Plan:
1. Reset, then start, is_div=0, a=7, b=6 → busy=1 for 32 cycles; done pulse in the 33rd cycle after start; hi=0, lo=0x0000002A.
2. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 issued in the DONE cycle → busy rises next cycle; result lo=14, hi=2.
3. DIVU a=0x00001234, b=0 → lo=0xFFFFFFFF, hi=0x00001234, done at the same cycle count as a normal divide.
4. MULTU in flight with rd_hilo=1 held from cycle 3 → stall=1 every cycle through the last RUN cycle; stall=0 in the DONE cycle; hi/lo match the product. wr_lo=1, wdata=0x55 during RUN → lo unchanged.
5. IDLE: wr_hi=1, wdata=0xDEADBEEF together with start MULTU a=2, b=3 → hi=0xDEADBEEF next cycle, then hi=0, lo=6 after completion.
6. rst pulsed asynchronously mid-clock at cycle 10 of a DIVU → busy, done, hi, lo go to 0 immediately. A new MULTU 3×5 after reset completes with lo=15.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the EX stage: one-bit-per-cycle unsigned multiply (MULTU)
// and restoring divide (DIVU), plus MTHI/MTLO writes and the HI/LO hazard stall.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             is_div;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    state_t           state;
    op_t              op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;   // P_hi for multiply, remainder R for divide
    logic [WIDTH-1:0] acc_lo;   // P_lo for multiply, quotient Q for divide

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // The remainder always ends a step below the divisor, so WIDTH bits hold it;
    // the extra shifted-out bit only matters for the compare.
    always_comb begin
        mul_sum = {1'b0, acc_hi};
        if (acc_lo[0])
            mul_sum = mul_sum + {1'b0, op.a};
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, op.b});
        div_diff = div_sh[WIDTH-1:0] - op.b;
        if (op.is_div) begin
            nxt_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= '0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (wr_hi)
                        hi <= wdata;
                    if (wr_lo)
                        lo <= wdata;
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        op.is_div <= is_div;
                        op.a      <= a;
                        op.b      <= b;
                        cnt       <= '0;
                        acc_hi    <= '0;
                        acc_lo    <= is_div ? a : b;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= nxt_hi;
                        lo    <= nxt_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // busy mirrors state==RUN, so MTHI/MTLO and new issues are held off here.
    assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO pushed at issue,
// popped and compared on every done pulse.
module tb_hilo_muldiv_ctrl;

    logic        clk, rst;
    logic        start, is_div, rd_hilo, wr_hi, wr_lo;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int nvec = 0;
    int nerr = 0;
    logic [63:0] sb[$];

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_div(is_div), .a(a), .b(b),
        .rd_hilo(rd_hilo), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit d, input logic [31:0] x, input logic [31:0] y);
        if (d)
            return (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Drives an issue for the current cycle, then drops start after the edge
    // and scrambles the operands, which must no longer matter.
    task automatic issue(input bit d, input logic [31:0] x, input logic [31:0] y);
        start  = 1'b1;
        is_div = d;
        a      = x;
        b      = y;
        sb.push_back(model(d, x, y));
        @(posedge clk); #1;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        is_div = 1'($urandom_range(0, 1));
    endtask

    // Called at posedge+1 right after issue; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag);
        int k  = 1;
        int nb = 0;
        bit seen = 1'b0;
        while (k <= 100 && !seen) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(posedge clk); #1;
                k++;
            end
        end
        chk({tag, "_lat"}, k, 33);
        chk({tag, "_busy_cycles"}, nb, 32);
    endtask

    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (!rst && done) begin
            if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_hi", hi, e[63:32]);
                chk("sb_lo", lo, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; is_div = 1'b0; a = '0; b = '0;
        rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);

        // 1: 7 x 6
        @(posedge clk); #1;
        issue(1'b0, 32'd7, 32'd6);
        wait_done("t1");

        // 2: max x max, then DIVU issued in the DONE cycle
        @(posedge clk); #1;
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("t2a");
        issue(1'b1, 32'd100, 32'd7);
        chk("t2_b2b_busy", busy, 1);
        chk("t2_b2b_done", done, 0);
        wait_done("t2b");

        // 3: divide by zero
        @(posedge clk); #1;
        issue(1'b1, 32'h00001234, 32'd0);
        wait_done("t3");

        // 4: hazards during RUN
        @(posedge clk); #1;
        issue(1'b0, 32'h12345678, 32'h9ABCDEF0);
        begin
            int k = 1;
            bit seen = 1'b0;
            while (k <= 100 && !seen) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    chk("t4_stall_done", stall, 0);
                end else begin
                    chk("t4_stall", stall, (k >= 3) ? 1 : 0);
                    if (k == 7) chk("t4_lo_hold", lo, 32'hFFFFFFFF);
                    @(posedge clk); #1;
                    if (k == 2) rd_hilo = 1'b1;
                    if (k == 5) begin wr_lo = 1'b1; wdata = 32'h55; end
                    if (k == 6) wr_lo = 1'b0;
                    if (k == 9) start = 1'b1;
                    if (k == 10) start = 1'b0;
                    k++;
                end
            end
            chk("t4_lat", k, 33);
        end
        rd_hilo = 1'b0;

        // 5: MTHI together with an IDLE issue
        @(posedge clk); #1;
        wr_hi = 1'b1;
        wdata = 32'hDEADBEEF;
        issue(1'b0, 32'd2, 32'd3);
        wr_hi = 1'b0;
        chk("t5_mthi", hi, 32'hDEADBEEF);
        wait_done("t5");

        // 6: async reset mid-divide
        @(posedge clk); #1;
        issue(1'b1, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_hi", hi, 0);
        chk("t6_lo", lo, 0);
        sb.delete();
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 32'd3, 32'd5);
        wait_done("t6");

        @(posedge clk); #1;
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
